rv32_mem_responder: RTL and testbench
=====================================

// Module: rv32_mem_responder
// PURPOSE
// - Memory-side responder for the RV32 core's instruction port (mem_i_*) and data port (mem_d_*).
// - Unified word-addressed RAM shared by both ports, so code and data live in one address space.
// - Each port has a strobe/busy handshake with a programmable number of wait states.
// - Used as the core's simulation/FPGA memory and as the target for core bring-up tests.
// PARAMETERS
// - ADDR_WIDTH  12  log2 of RAM depth in 32-bit words (default 4096 words)
// - BASE_ADDR   0   byte address of word 0; must be 4-byte aligned
// - I_WAIT      1   wait states on the instruction port (0..15)
// - D_WAIT      1   wait states on the data port, reads and writes (0..15)
// PORTS
// - clk          in   1   clock
// - rst          in   1   reset: synchronous, active-high
// - mem_i_addr   in   32  instruction fetch byte address
// - mem_i_rstrb  in   1   fetch request; held high until accepted
// - mem_i_rdata  out  32  fetch data; valid when rstrb=1 and rbusy=0
// - mem_i_rbusy  out  1   fetch not ready
// - mem_d_addr   in   32  data byte address
// - mem_d_wdata  in   32  store data, already lane-replicated by the core
// - mem_d_wmask  in   4   byte-lane write enables; bit n enables wdata[8n+7:8n]
// - mem_d_wstrb  in   1   store request; held high until accepted
// - mem_d_rstrb  in   1   load request; held high until accepted
// - mem_d_rdata  out  32  load data (full word); valid when rstrb=1 and rbusy=0
// - mem_d_rbusy  out  1   load not ready
// - mem_d_wbusy  out  1   store not complete
// BEHAVIOUR
// - Per-port FSM with states IDLE, WAIT, READY and a 4-bit counter cnt. The two ports are independent.
// - IDLE, strobe=1: busy=1.
//   - If WAIT==0: capture RAM word, go to READY.
//   - Otherwise: cnt<=WAIT-1, go to WAIT.
// - WAIT: busy=1. cnt!=0 -> cnt--. cnt==0 -> capture RAM word, go to READY.
// - READY: busy=0.
//   - strobe=1 is the accept cycle. A store commits on this edge; the FSM returns to IDLE.
//   - strobe=0 means the access is abandoned: no write, go to IDLE.
// - Busy outputs are combinational: busy = strobe && (state!=READY).
//   - Every accepted access sees exactly WAIT+1 busy cycles; first-cycle data is never valid.
//   - With no strobe, busy=0.
// - Back-to-back: after an accept cycle the FSM is in IDLE, so a strobe in the next cycle starts a new access.
// - Addressing: word index = (addr-BASE_ADDR)>>2; addr[1:0] is ignored.
//   - Out-of-range loads and fetches return 32'h0.
//   - Out-of-range stores are dropped; the handshake timing is unchanged.
// - Stores: a read-modify-write per byte lane under wmask. wmask=0 writes nothing but still completes.
// - Data port with rstrb and wstrb both high: treated as a store. wbusy and rbusy follow the same FSM.
//   rdata returns the word as it was before the store.
// - Ordering: rdata is held in a register captured when the FSM enters READY.
//   - An I-port word already in READY is not updated by a D-port store committing later; the fetch sees the old value.
//   - A capture and a commit on the same edge to the same word: the capture sees the old value.
// - Reset: both FSMs go to IDLE, cnt=0, mem_i_rdata=0, mem_d_rdata=0, busy outputs = strobe.
//   RAM contents are not cleared.
// - Reset during WAIT or READY: the access is discarded and no store commits.
// CONFIGURATION
// - MEM_RAND_WAIT_EN defined:
//   - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every cycle.
//   - On entry from IDLE, the port's wait count = base WAIT + lfsr[1:0] (I port) or + lfsr[3:2] (D port).
//   - Used to stress the core's freeze logic.
// - MEM_RAND_WAIT_EN not defined: the wait count is exactly I_WAIT/D_WAIT; the LFSR is absent.
// TESTING
// - I_WAIT=0: preload word 0 = 32'h00000013; rstrb addr 0 -> rbusy=1 for 1 cycle, then rdata=32'h00000013 with rbusy=0.
// - D_WAIT=3: store addr 0x104 wdata 32'hDEADBEEF wmask 4'hF -> wbusy=1 for 4 cycles;
//   a later load at 0x104 returns 32'hDEADBEEF.
// - Byte store: addr 0x105, wdata 32'h5A5A5A5A, wmask 4'b0010 over 32'hDEADBEEF -> load returns 32'hDEAD5AEF.
// - Out of range (ADDR_WIDTH=12): load at 0x4000 -> rdata 0, normal busy timing;
//   store at 0x4000 leaves all words unchanged.
// - Concurrency: I fetch and D store to the same word in the same cycle, both WAIT=0
//   -> fetch returns the old word; the next fetch returns the new word.
// - Reset mid-store: rst=1 during WAIT -> busy follows strobe, FSM in IDLE, target word unchanged.

Source files
------------

// File: rtl/rv32_mem_responder_if.sv
// Instruction-fetch and data-access bus between the RV32 core (master) and its memory (slave).
interface rv32_mem_responder_if;
  logic [31:0] mem_i_addr;
  logic        mem_i_rstrb;
  logic [31:0] mem_i_rdata;
  logic        mem_i_rbusy;

  logic [31:0] mem_d_addr;
  logic [31:0] mem_d_wdata;
  logic [3:0]  mem_d_wmask;
  logic        mem_d_wstrb;
  logic        mem_d_rstrb;
  logic [31:0] mem_d_rdata;
  logic        mem_d_rbusy;
  logic        mem_d_wbusy;

  modport master (
    output mem_i_addr, mem_i_rstrb,
    input  mem_i_rdata, mem_i_rbusy,
    output mem_d_addr, mem_d_wdata, mem_d_wmask, mem_d_wstrb, mem_d_rstrb,
    input  mem_d_rdata, mem_d_rbusy, mem_d_wbusy
  );

  modport slave (
    input  mem_i_addr, mem_i_rstrb,
    output mem_i_rdata, mem_i_rbusy,
    input  mem_d_addr, mem_d_wdata, mem_d_wmask, mem_d_wstrb, mem_d_rstrb,
    output mem_d_rdata, mem_d_rbusy, mem_d_wbusy
  );
endinterface

// File: rtl/rv32_mem_responder.sv
// Unified word RAM answering the RV32 instruction and data ports with programmable wait states.
// Optional MEM_RAND_WAIT_EN adds an LFSR-driven random extension of 0..3 wait states per access.
module rv32_mem_responder #(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int          I_WAIT     = 1,
  parameter int          D_WAIT     = 1
) (
  input logic                 clk,
  input logic                 rst,
  rv32_mem_responder_if.slave bus
);
  localparam int NPORT = 2;
`ifdef MEM_RAND_WAIT_EN
  localparam int CNT_W = 5;
`else
  localparam int CNT_W = 4;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_READY} state_t;

  logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];

  // Port 0 is the instruction port, port 1 the data port.
  logic [NPORT-1:0]      port_strb;
  logic [NPORT-1:0]      port_busy;
  logic [NPORT-1:0]      port_accept;
  logic [NPORT-1:0]      port_in_range;
  logic [31:0]           port_addr  [NPORT];
  logic [31:0]           port_rdata [NPORT];
  logic [ADDR_WIDTH-1:0] port_idx   [NPORT];
  logic                  d_commit;

`ifdef MEM_RAND_WAIT_EN
  logic [15:0] lfsr_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_reg <= 16'hACE1;
    end else begin
      lfsr_reg <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
    end
  end
`endif

  assign port_strb    = {bus.mem_d_rstrb | bus.mem_d_wstrb, bus.mem_i_rstrb};
  assign port_addr[0] = bus.mem_i_addr;
  assign port_addr[1] = bus.mem_d_addr;

  for (genvar gi = 0; gi < NPORT; gi++) begin : g_port
    localparam int BASE_WAIT = (gi == 0) ? I_WAIT : D_WAIT;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] wait_total;
    logic             capture;
    logic [31:0]      rdata_reg;
    logic [31:0]      offset;

    // A wrapped subtraction (addr below BASE_ADDR) lands far out of range.
    assign offset            = port_addr[gi] - BASE_ADDR;
    assign port_in_range[gi] = (offset >> (ADDR_WIDTH + 2)) == '0;
    assign port_idx[gi]      = offset[ADDR_WIDTH+1:2];

`ifdef MEM_RAND_WAIT_EN
    assign wait_total = CNT_W'(BASE_WAIT) + CNT_W'(lfsr_reg[2*gi +: 2]);
`else
    assign wait_total = CNT_W'(BASE_WAIT);
`endif

    always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      capture    = 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (port_strb[gi]) begin
            if (wait_total == '0) begin
              capture    = 1'b1;
              state_next = ST_READY;
            end else begin
              cnt_next   = wait_total - 1'b1;
              state_next = ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_reg != '0) begin
            cnt_next = cnt_reg - 1'b1;
          end else begin
            capture    = 1'b1;
            state_next = ST_READY;
          end
        end
        ST_READY: state_next = ST_IDLE;
        default:  state_next = ST_IDLE;
      endcase
    end

    // The captured word is frozen until the next capture, so later stores do not disturb it.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_reg <= ST_IDLE;
        cnt_reg   <= '0;
        rdata_reg <= '0;
      end else begin
        state_reg <= state_next;
        cnt_reg   <= cnt_next;
        if (capture) begin
          rdata_reg <= port_in_range[gi] ? mem[port_idx[gi]] : 32'h0;
        end
      end
    end

    assign port_busy[gi]   = port_strb[gi] && (state_reg != ST_READY);
    assign port_accept[gi] = port_strb[gi] && (state_reg == ST_READY);
    assign port_rdata[gi]  = rdata_reg;
  end

  assign d_commit = port_accept[1] && bus.mem_d_wstrb && port_in_range[1];

  always_ff @(posedge clk) begin
    if (!rst && d_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.mem_d_wmask[b]) begin
          mem[port_idx[1]][8*b +: 8] <= bus.mem_d_wdata[8*b +: 8];
        end
      end
    end
  end

  assign bus.mem_i_rdata = port_rdata[0];
  assign bus.mem_i_rbusy = port_busy[0];
  assign bus.mem_d_rdata = port_rdata[1];
  assign bus.mem_d_rbusy = bus.mem_d_rstrb && port_busy[1];
  assign bus.mem_d_wbusy = bus.mem_d_wstrb && port_busy[1];
endmodule

// File: tb/tb_rv32_mem_responder.sv
// Directed and randomized checks of rv32_mem_responder against a word-array reference model.
module tb_rv32_mem_responder;
  localparam int          ADDR_WIDTH = 12;
  localparam logic [31:0] BASE_ADDR  = 32'h0;
  localparam int          I_WAIT     = 0;
  localparam int          D_WAIT     = 3;
  localparam int          MAX_WAIT   = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  logic [31:0] model_mem [int unsigned];

  rv32_mem_responder_if bus ();

  rv32_mem_responder #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BASE_ADDR  (BASE_ADDR),
    .I_WAIT     (I_WAIT),
    .D_WAIT     (D_WAIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic bit model_in_range(input logic [31:0] addr);
    longint unsigned widx;
    widx = longint'((addr - BASE_ADDR) >> 2);
    return widx < (longint'(1) << ADDR_WIDTH);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr);
    int unsigned widx;
    widx = (addr - BASE_ADDR) >> 2;
    if (!model_in_range(addr)) return 32'h0;
    if (model_mem.exists(widx)) return model_mem[widx];
    return 32'h0;
  endfunction

  task automatic model_store(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] mask);
    int unsigned widx;
    logic [31:0] w;
    widx = (addr - BASE_ADDR) >> 2;
    if (!model_in_range(addr)) return;
    w = model_mem.exists(widx) ? model_mem[widx] : 32'h0;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) w[8*b +: 8] = wdata[8*b +: 8];
    end
    model_mem[widx] = w;
  endtask

  // Runs one data-port access; counts busy cycles of the governing busy output.
  task automatic d_access(input logic do_wr, input logic do_rd, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] mask,
                          output logic [31:0] rd, output int nbusy);
    @(negedge clk);
    bus.mem_d_addr  = addr;
    bus.mem_d_wdata = wdata;
    bus.mem_d_wmask = mask;
    bus.mem_d_wstrb = do_wr;
    bus.mem_d_rstrb = do_rd;
    nbusy = 0;
    #1;
    while ((do_wr ? bus.mem_d_wbusy : bus.mem_d_rbusy) && nbusy < MAX_WAIT) begin
      nbusy++;
      @(negedge clk);
      #1;
    end
    rd = bus.mem_d_rdata;
    @(posedge clk);
    #1;
    bus.mem_d_wstrb = 1'b0;
    bus.mem_d_rstrb = 1'b0;
  endtask

  task automatic i_fetch(input logic [31:0] addr, output logic [31:0] rd, output int nbusy);
    @(negedge clk);
    bus.mem_i_addr  = addr;
    bus.mem_i_rstrb = 1'b1;
    nbusy = 0;
    #1;
    while (bus.mem_i_rbusy && nbusy < MAX_WAIT) begin
      nbusy++;
      @(negedge clk);
      #1;
    end
    rd = bus.mem_i_rdata;
    @(posedge clk);
    #1;
    bus.mem_i_rstrb = 1'b0;
  endtask

  task automatic do_store(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] mask);
    logic [31:0] rd;
    int nb;
    d_access(1'b1, 1'b0, addr, wdata, mask, rd, nb);
    check({tag, "_wbusy"}, 32'(nb), 32'(D_WAIT + 1));
    model_store(addr, wdata, mask);
  endtask

  task automatic do_load(input string tag, input logic [31:0] addr);
    logic [31:0] rd;
    int nb;
    d_access(1'b0, 1'b1, addr, 32'h0, 4'h0, rd, nb);
    check({tag, "_rbusy"}, 32'(nb), 32'(D_WAIT + 1));
    check({tag, "_rdata"}, rd, model_load(addr));
  endtask

  task automatic do_fetch(input string tag, input logic [31:0] addr);
    logic [31:0] rd;
    int nb;
    i_fetch(addr, rd, nb);
    check({tag, "_ibusy"}, 32'(nb), 32'(I_WAIT + 1));
    check({tag, "_idata"}, rd, model_load(addr));
  endtask

  initial begin
    logic [31:0] rd, exp, addr, wdata;
    logic [3:0]  mask;
    int          nb, kind;

    bus.mem_i_addr  = 32'h0;
    bus.mem_i_rstrb = 1'b0;
    bus.mem_d_addr  = 32'h0;
    bus.mem_d_wdata = 32'h0;
    bus.mem_d_wmask = 4'h0;
    bus.mem_d_wstrb = 1'b0;
    bus.mem_d_rstrb = 1'b0;

    // Reset state: data registers cleared, busy simply mirrors the strobe.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_i_rdata", bus.mem_i_rdata, 32'h0);
    check("rst_d_rdata", bus.mem_d_rdata, 32'h0);
    bus.mem_i_rstrb = 1'b1;
    bus.mem_d_wstrb = 1'b1;
    #1;
    check("rst_i_busy_hi", 32'(bus.mem_i_rbusy), 32'h1);
    check("rst_d_wbusy_hi", 32'(bus.mem_d_wbusy), 32'h1);
    bus.mem_i_rstrb = 1'b0;
    bus.mem_d_wstrb = 1'b0;
    #1;
    check("rst_i_busy_lo", 32'(bus.mem_i_rbusy), 32'h0);
    check("rst_d_wbusy_lo", 32'(bus.mem_d_wbusy), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    do_store("preload0", 32'h0, 32'h00000013, 4'hF);
    do_fetch("fetch0", 32'h0);
    do_store("st104", 32'h104, 32'hDEADBEEF, 4'hF);
    do_load("ld104", 32'h104);
    check("ld104_const", model_load(32'h104), 32'hDEADBEEF);
    do_store("st105b", 32'h105, 32'h5A5A5A5A, 4'b0010);
    do_load("ld104b", 32'h104);
    check("ld104b_const", model_load(32'h104), 32'hDEAD5AEF);

    do_load("oor_ld", 32'h4000);
    do_store("oor_st", 32'h4000, 32'hFFFFFFFF, 4'hF);
    do_load("oor_w0", 32'h0);
    do_load("oor_w104", 32'h104);
    do_fetch("oor_fetch", 32'h4000);

    // Load and store strobed together: rdata is the word before the store.
    exp = model_load(32'h104);
    d_access(1'b1, 1'b1, 32'h104, 32'h11111111, 4'b0001, rd, nb);
    check("rw_wbusy", 32'(nb), 32'(D_WAIT + 1));
    check("rw_rdata", rd, exp);
    model_store(32'h104, 32'h11111111, 4'b0001);
    do_load("rw_after", 32'h104);
    do_store("mask0", 32'h104, 32'hFFFFFFFF, 4'h0);
    do_load("mask0_ld", 32'h104);

    // Fetch captures on the same edge the store commits: fetch sees the old word.
    do_store("cc_pre", 32'h200, 32'hA0A0A0A0, 4'hF);
    @(negedge clk);
    bus.mem_d_addr  = 32'h200;
    bus.mem_d_wdata = 32'h0BADF00D;
    bus.mem_d_wmask = 4'hF;
    bus.mem_d_wstrb = 1'b1;
    nb = 0;
    #1;
    while (bus.mem_d_wbusy && nb < MAX_WAIT) begin
      nb++;
      @(negedge clk);
      #1;
    end
    check("cc_wbusy", 32'(nb), 32'(D_WAIT + 1));
    bus.mem_i_addr  = 32'h200;
    bus.mem_i_rstrb = 1'b1;
    #1;
    check("cc_ibusy", 32'(bus.mem_i_rbusy), 32'h1);
    @(posedge clk);
    #1;
    bus.mem_d_wstrb = 1'b0;
    @(negedge clk);
    #1;
    check("cc_ibusy_rdy", 32'(bus.mem_i_rbusy), 32'h0);
    check("cc_old", bus.mem_i_rdata, 32'hA0A0A0A0);
    @(posedge clk);
    #1;
    bus.mem_i_rstrb = 1'b0;
    model_store(32'h200, 32'h0BADF00D, 4'hF);
    do_fetch("cc_new", 32'h200);

    // Reset in the middle of a store's wait states: nothing commits.
    @(negedge clk);
    bus.mem_d_addr  = 32'h104;
    bus.mem_d_wdata = 32'hFFFF0000;
    bus.mem_d_wmask = 4'hF;
    bus.mem_d_wstrb = 1'b1;
    @(negedge clk);
    #1;
    check("mrst_wbusy_wait", 32'(bus.mem_d_wbusy), 32'h1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("mrst_wbusy_strb", 32'(bus.mem_d_wbusy), 32'h1);
    check("mrst_d_rdata", bus.mem_d_rdata, 32'h0);
    bus.mem_d_wstrb = 1'b0;
    #1;
    check("mrst_wbusy_lo", 32'(bus.mem_d_wbusy), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    do_load("mrst_ld", 32'h104);

    // Randomized traffic over a small window, with occasional out-of-range addresses.
    for (int k = 0; k < 8; k++) begin
      do_store("rnd_init", 32'h300 + 32'(4 * k), $urandom, 4'hF);
    end
    for (int t = 0; t < 60; t++) begin
      kind  = $urandom_range(0, 3);
      addr  = 32'h300 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) addr = addr + 32'h4000;
      wdata = $urandom;
      mask  = 4'($urandom_range(0, 15));
      case (kind)
        0: do_store("rnd_st", addr, wdata, mask);
        1: do_load("rnd_ld", addr);
        2: begin
          exp = model_load(addr);
          d_access(1'b1, 1'b1, addr, wdata, mask, rd, nb);
          check("rnd_rw_wbusy", 32'(nb), 32'(D_WAIT + 1));
          check("rnd_rw_rdata", rd, exp);
          model_store(addr, wdata, mask);
        end
        default: do_fetch("rnd_fetch", addr);
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
